// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game controller.
//   dir_t          : snake heading, DIRECTION_SIZE bits
//   game_state_t   : externally visible game state code (character generator)
//   fsm_t          : internal sequencer states (CLEAR split into two phases)
//   opposite()     : reverse of a heading
//   encode_state() : internal FSM state -> visible game state code
package snake_pkg;

    localparam int unsigned DIRECTION_SIZE = 2;
    localparam int unsigned LEVEL_W        = 3;
    localparam int unsigned STATE_W        = 3;

    typedef enum logic [DIRECTION_SIZE-1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_PLAYING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_OVER    = 3'd4
    } game_state_t;

    typedef enum logic [2:0] {
        F_IDLE    = 3'd0,
        F_CLEAR1  = 3'd1,
        F_CLEAR2  = 3'd2,
        F_PLAYING = 3'd3,
        F_PAUSED  = 3'd4,
        F_OVER    = 3'd5
    } fsm_t;

    function automatic dir_t opposite(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            default: r = LEFT;
        endcase
        return r;
    endfunction

    function automatic game_state_t encode_state(input fsm_t s);
        game_state_t r;
        case (s)
            F_IDLE:             r = ST_IDLE;
            F_CLEAR1, F_CLEAR2: r = ST_CLEAR;
            F_PLAYING:          r = ST_PLAYING;
            F_PAUSED:           r = ST_PAUSED;
            F_OVER:             r = ST_OVER;
            default:            r = ST_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_game_controller_if.sv
// Control bundle between the game controller and its neighbours
// (PS/2 decoder, VGA sync, snake/apple datapath).
//   master : the controller (consumes events, drives reset_game/move_tick/
//            direction/level/state)
//   slave  : the surrounding logic (drives events, consumes controls)
interface snake_game_controller_if;
    import snake_pkg::*;

    logic                 frame_start;
    logic                 start_key;
    logic                 pause_key;
    logic                 dir_valid;
    dir_t                 dir_req;
    logic                 apple_eaten;
    logic                 game_over_in;

    logic                 reset_game;
    logic                 move_tick;
    dir_t                 direction;
    logic [LEVEL_W-1:0]   level;
    game_state_t          state;

    modport master (
        input  frame_start, start_key, pause_key, dir_valid, dir_req,
               apple_eaten, game_over_in,
        output reset_game, move_tick, direction, level, state
    );

    modport slave (
        output frame_start, start_key, pause_key, dir_valid, dir_req,
               apple_eaten, game_over_in,
        input  reset_game, move_tick, direction, level, state
    );

endinterface

// File: rtl/move_tick_gen.sv
// Frame counter and move-tick generator.
//   clk_25, rst     : clock, synchronous active-high reset
//   i_level         : current level, selects frames per move
//   i_enable        : count frame_start pulses (steady PLAYING only)
//   i_clear         : zero the frame counter
//   i_force         : force a tick next cycle (datapath clear)
//   i_frame_start   : one pulse per video frame
//   o_tick          : registered one-cycle move enable
//   o_tick_set_c    : combinational, high on the edge where o_tick rises
//                     from frame counting
module move_tick_gen
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = 8,
    parameter int unsigned PERIOD_STEP = 1,
    parameter int unsigned MIN_PERIOD  = 2
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] i_level,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic               i_force,
    input  logic               i_frame_start,
    output logic               o_tick,
    output logic               o_tick_set_c
);
    localparam int unsigned PW  = 5;
    localparam int unsigned CW  = 4;
    localparam logic [PW-1:0] BASE_P = PW'(BASE_PERIOD);
    localparam logic [PW-1:0] MIN_P  = PW'(MIN_PERIOD);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic [PW-1:0] w_dec;
    logic [PW-1:0] w_period;
    logic          w_last;

    // Period with clamp; a subtraction that would go negative yields MIN.
    always_comb begin
        w_dec = PW'(i_level) * PW'(PERIOD_STEP);
        if ((w_dec >= BASE_P) || ((BASE_P - w_dec) < MIN_P)) begin
            w_period = MIN_P;
        end else begin
            w_period = BASE_P - w_dec;
        end
        w_last       = ({1'b0, r_cnt} == (w_period - PW'(1)));
        o_tick_set_c = i_enable & i_frame_start & w_last;
    end

    // Frame counter and tick register
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_force | o_tick_set_c;
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_enable && i_frame_start) begin
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/snake_game_controller.sv
// Snake game sequencer: game FSM, datapath reset, level tracking and
// direction filtering; move ticks come from move_tick_gen.
//   clk_25 : 25 MHz pixel clock
//   rst    : synchronous active-high reset
//   bus    : control bundle (events in; reset_game, move_tick, direction,
//            level, state out -- all registered)
module snake_game_controller
    import snake_pkg::*;
#(
    parameter int unsigned BASE_PERIOD      = 8,
    parameter int unsigned PERIOD_STEP      = 1,
    parameter int unsigned MIN_PERIOD       = 2,
    parameter int unsigned APPLES_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL        = 7
) (
    input  logic                    clk_25,
    input  logic                    rst,
    snake_game_controller_if.master bus
);
    localparam int unsigned AW = 3;
    localparam logic [AW-1:0]      APPLE_LAST = AW'(APPLES_PER_LEVEL - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    fsm_t               r_fsm;
    fsm_t               w_fsm_next;
    logic               r_reset_game;
    game_state_t        r_state;
    logic [LEVEL_W-1:0] r_level;
    logic [AW-1:0]      r_apple_cnt;
    dir_t               r_direction;
    dir_t               r_pending;
    logic               r_pending_vld;

    logic               w_clear;
    logic               w_force_tick;
    logic               w_tick_enable;
    logic               w_playing;
    logic               w_tick;
    logic               w_tick_set;
    dir_t               w_dir_next;
    logic               w_dir_accept;

    // State register
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_fsm <= F_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Next state and per-transition controls
    always_comb begin
        w_fsm_next    = r_fsm;
        w_clear       = 1'b0;
        w_force_tick  = 1'b0;
        w_tick_enable = 1'b0;
        case (r_fsm)
            F_IDLE:    if (bus.start_key) w_fsm_next = F_CLEAR1;
            F_CLEAR1:  w_fsm_next = F_CLEAR2;
            F_CLEAR2:  w_fsm_next = F_PLAYING;
            F_PLAYING: begin
                if (bus.game_over_in) begin
                    w_fsm_next = F_OVER;
                end else if (bus.pause_key) begin
                    w_fsm_next = F_PAUSED;
                end
            end
            F_PAUSED:  if (bus.pause_key) w_fsm_next = F_PLAYING;
            F_OVER:    if (bus.start_key) w_fsm_next = F_CLEAR1;
            default:   w_fsm_next = F_IDLE;
        endcase
        w_clear       = (w_fsm_next == F_CLEAR1) || (w_fsm_next == F_CLEAR2);
        w_force_tick  = (w_fsm_next == F_CLEAR1);
        // A frame arriving as we leave PLAYING is not counted.
        w_tick_enable = (r_fsm == F_PLAYING) && (w_fsm_next == F_PLAYING);
    end

    assign w_playing = (r_fsm == F_PLAYING);

    // Visible state and datapath reset track the state being entered
    always_ff @(posedge clk_25) begin
        if (rst) begin
            r_reset_game <= 1'b1;
            r_state      <= ST_IDLE;
        end else begin
            r_reset_game <= (w_fsm_next == F_IDLE) || w_clear;
            r_state      <= encode_state(w_fsm_next);
        end
    end

    move_tick_gen #(
        .BASE_PERIOD (BASE_PERIOD),
        .PERIOD_STEP (PERIOD_STEP),
        .MIN_PERIOD  (MIN_PERIOD)
    ) u_tick (
        .clk_25        (clk_25),
        .rst           (rst),
        .i_level       (r_level),
        .i_enable      (w_tick_enable),
        .i_clear       (w_clear),
        .i_force       (w_force_tick),
        .i_frame_start (bus.frame_start),
        .o_tick        (w_tick),
        .o_tick_set_c  (w_tick_set)
    );

    // Apple counter and saturating level
    always_ff @(posedge clk_25) begin
        if (rst || w_clear) begin
            r_level     <= '0;
            r_apple_cnt <= '0;
        end else if (w_playing && bus.apple_eaten) begin
            if (r_apple_cnt == APPLE_LAST) begin
                r_apple_cnt <= '0;
                if (r_level != LEVEL_MAX) begin
                    r_level <= r_level + LEVEL_W'(1);
                end
            end else begin
                r_apple_cnt <= r_apple_cnt + AW'(1);
            end
        end
    end

    // Direction filter. On the commit edge a new request is judged against
    // the heading being committed, so it can never reverse it next move.
    always_comb begin
        w_dir_next   = (w_tick_set && r_pending_vld) ? r_pending : r_direction;
        w_dir_accept = w_playing && bus.dir_valid &&
                       (bus.dir_req != w_dir_next) &&
                       (bus.dir_req != opposite(w_dir_next));
    end

    always_ff @(posedge clk_25) begin
        if (rst || w_clear) begin
            r_direction   <= RIGHT;
            r_pending     <= RIGHT;
            r_pending_vld <= 1'b0;
        end else begin
            r_direction <= w_dir_next;
            if (w_dir_accept) begin
                r_pending     <= bus.dir_req;
                r_pending_vld <= 1'b1;
            end else if (w_tick_set) begin
                r_pending_vld <= 1'b0;
            end
        end
    end

    assign bus.reset_game = r_reset_game;
    assign bus.move_tick  = w_tick;
    assign bus.direction  = r_direction;
    assign bus.level      = r_level;
    assign bus.state      = r_state;

endmodule

// File: tb/tb_snake_game_controller.sv
// Bench for snake_game_controller: directed scenarios with literal
// expectations, then randomized events, all outputs checked every cycle
// against a behavioural game model.
module tb_snake_game_controller;
    import snake_pkg::*;

    localparam int BASE = 8;
    localparam int STEP = 1;
    localparam int MINP = 2;
    localparam int APL  = 5;
    localparam int MAXL = 7;

    localparam logic [7:0] EV_FS  = 8'h01;
    localparam logic [7:0] EV_SK  = 8'h02;
    localparam logic [7:0] EV_PK  = 8'h04;
    localparam logic [7:0] EV_DV  = 8'h08;
    localparam logic [7:0] EV_AP  = 8'h10;
    localparam logic [7:0] EV_GO  = 8'h20;
    localparam logic [7:0] EV_RST = 8'h40;

    localparam int MD_IDLE  = 0;
    localparam int MD_CLEAR = 1;
    localparam int MD_PLAY  = 2;
    localparam int MD_PAUSE = 3;
    localparam int MD_OVER  = 4;

    logic clk_25 = 1'b0;
    logic rst;
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   tick_seen = 0;
    bit   chk_on    = 1'b0;

    snake_game_controller_if bus ();

    snake_game_controller #(
        .BASE_PERIOD      (BASE),
        .PERIOD_STEP      (STEP),
        .MIN_PERIOD       (MINP),
        .APPLES_PER_LEVEL (APL),
        .MAX_LEVEL        (MAXL)
    ) dut (
        .clk_25 (clk_25),
        .rst    (rst),
        .bus    (bus)
    );

    always #20 clk_25 = ~clk_25;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int   m_mode;
    int   m_frames;
    int   m_apples;
    int   m_level;
    int   m_period;
    bit   m_clear_first;
    bit   m_pend_ok;
    dir_t m_dir;
    dir_t m_pend;
    logic e_tick;

    function automatic dir_t m_reverse(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    function automatic game_state_t m_state_code(input int md);
        case (md)
            MD_CLEAR: return ST_CLEAR;
            MD_PLAY:  return ST_PLAYING;
            MD_PAUSE: return ST_PAUSED;
            MD_OVER:  return ST_OVER;
            default:  return ST_IDLE;
        endcase
    endfunction

    task model_reset();
        m_mode = MD_IDLE; m_frames = 0; m_apples = 0; m_level = 0;
        m_dir = RIGHT; m_pend = RIGHT; m_pend_ok = 1'b0;
        m_clear_first = 1'b0; e_tick = 1'b0;
    endtask

    task model_enter_clear();
        m_mode = MD_CLEAR; m_clear_first = 1'b1;
        m_frames = 0; m_apples = 0; m_level = 0;
        m_dir = RIGHT; m_pend_ok = 1'b0;
        e_tick = 1'b1;
    endtask

    always @(posedge clk_25) begin
        if (rst) begin
            model_reset();
        end else begin
            e_tick = 1'b0;
            case (m_mode)
                MD_IDLE: if (bus.start_key) model_enter_clear();
                MD_CLEAR: begin
                    if (m_clear_first) m_clear_first = 1'b0;
                    else m_mode = MD_PLAY;
                end
                MD_PLAY: begin
                    m_period = BASE - m_level * STEP;
                    if (m_period < MINP) m_period = MINP;
                    if (bus.frame_start && !bus.game_over_in && !bus.pause_key) begin
                        if (m_frames == m_period - 1) begin
                            m_frames = 0;
                            e_tick   = 1'b1;
                        end else begin
                            m_frames = (m_frames + 1) % 16;
                        end
                    end
                    if (e_tick && m_pend_ok) begin
                        m_dir     = m_pend;
                        m_pend_ok = 1'b0;
                    end
                    if (bus.dir_valid && bus.dir_req != m_dir && bus.dir_req != m_reverse(m_dir)) begin
                        m_pend    = bus.dir_req;
                        m_pend_ok = 1'b1;
                    end
                    if (bus.apple_eaten) begin
                        m_apples++;
                        if (m_apples == APL) begin
                            m_apples = 0;
                            if (m_level < MAXL) m_level++;
                        end
                    end
                    if (bus.game_over_in) m_mode = MD_OVER;
                    else if (bus.pause_key) m_mode = MD_PAUSE;
                end
                MD_PAUSE: if (bus.pause_key) m_mode = MD_PLAY;
                MD_OVER:  if (bus.start_key) model_enter_clear();
                default:  m_mode = MD_IDLE;
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk_25) begin
        if (chk_on) begin
            check("reset_game", 8'(bus.reset_game), 8'(m_mode == MD_IDLE || m_mode == MD_CLEAR));
            check("move_tick",  8'(bus.move_tick),  8'(e_tick));
            check("direction",  8'(bus.direction),  8'(m_dir));
            check("level",      8'(bus.level),      8'(m_level));
            check("state",      8'(bus.state),      8'(m_state_code(m_mode)));
        end
    end

    always @(negedge clk_25) begin
        if (bus.move_tick === 1'b1) tick_seen++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [7:0] ev, input dir_t dr);
        @(negedge clk_25);
        bus.frame_start  = ev[0];
        bus.start_key    = ev[1];
        bus.pause_key    = ev[2];
        bus.dir_valid    = ev[3];
        bus.apple_eaten  = ev[4];
        bus.game_over_in = ev[5];
        rst              = ev[6];
        bus.dir_req      = dr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(8'h00, RIGHT);
    endtask

    task automatic frame();
        step(EV_FS, RIGHT);
        idle(3);
    endtask

    task automatic apples(input int n);
        for (int i = 0; i < n; i++) begin
            step(EV_AP, RIGHT);
            idle(1);
        end
    endtask

    task automatic run_to_tick(input int max_frames, output int nfr);
        int t0;
        t0  = tick_seen;
        nfr = 0;
        while (tick_seen == t0 && nfr < max_frames) begin
            frame();
            nfr++;
        end
        n_checks++;
        if (tick_seen == t0) begin
            n_errors++;
            $display("FAIL tick_wait: no move_tick within %0d frames", max_frames);
        end
    endtask

    initial begin
        int t0;
        int nfr;
        logic [7:0] ev;
        bus.frame_start = 1'b0; bus.start_key = 1'b0; bus.pause_key = 1'b0;
        bus.dir_valid = 1'b0; bus.dir_req = RIGHT; bus.apple_eaten = 1'b0;
        bus.game_over_in = 1'b0; rst = 1'b1;

        // Reset
        step(EV_RST, RIGHT);
        chk_on = 1'b1;
        step(EV_RST, RIGHT);
        idle(2);
        check("rst_state", 8'(bus.state), 8'(ST_IDLE));
        check("rst_reset_game", 8'(bus.reset_game), 8'd1);
        check("rst_tick", 8'(bus.move_tick), 8'd0);
        check("rst_dir", 8'(bus.direction), 8'(RIGHT));
        check("rst_level", 8'(bus.level), 8'd0);

        // Start: two CLEAR cycles, forced tick in the first
        t0 = tick_seen;
        step(EV_SK, RIGHT);
        idle(1);
        check("clr1_state", 8'(bus.state), 8'(ST_CLEAR));
        check("clr1_rg", 8'(bus.reset_game), 8'd1);
        check("clr1_tick", 8'(bus.move_tick), 8'd1);
        idle(1);
        check("clr2_state", 8'(bus.state), 8'(ST_CLEAR));
        check("clr2_rg", 8'(bus.reset_game), 8'd1);
        check("clr2_tick", 8'(bus.move_tick), 8'd0);
        idle(1);
        check("play_state", 8'(bus.state), 8'(ST_PLAYING));
        check("play_rg", 8'(bus.reset_game), 8'd0);
        check("clear_ticks", 8'(tick_seen - t0), 8'd1);

        // Level 0: 40 frames -> 5 moves
        t0 = tick_seen;
        repeat (40) frame();
        check("lvl0_ticks", 8'(tick_seen - t0), 8'd5);

        // Level 1 after 5 apples, period 7
        apples(5);
        check("lvl1", 8'(bus.level), 8'd1);
        run_to_tick(20, nfr);
        check("period7", 8'(nfr), 8'd7);

        // Direction filter
        step(EV_DV, LEFT);
        run_to_tick(20, nfr);
        check("reverse_rejected", 8'(bus.direction), 8'(RIGHT));
        step(EV_DV, UP);
        step(EV_DV, DOWN);
        step(EV_DV, LEFT);
        run_to_tick(20, nfr);
        check("last_turn_wins", 8'(bus.direction), 8'(DOWN));

        // Game over together with the 5th apple of level 1
        apples(4);
        step(EV_AP | EV_GO, RIGHT);
        idle(1);
        check("over_state", 8'(bus.state), 8'(ST_OVER));
        check("over_apple_counted", 8'(bus.level), 8'd2);
        t0 = tick_seen;
        repeat (20) frame();
        check("over_no_ticks", 8'(tick_seen - t0), 8'd0);
        step(EV_SK, RIGHT);
        idle(1);
        check("restart_state", 8'(bus.state), 8'(ST_CLEAR));
        check("restart_level", 8'(bus.level), 8'd0);
        check("restart_dir", 8'(bus.direction), 8'(RIGHT));
        idle(2);
        check("restart_play", 8'(bus.state), 8'(ST_PLAYING));

        // Level saturation and MIN period clamp
        apples(35);
        check("lvl7", 8'(bus.level), 8'd7);
        run_to_tick(20, nfr);
        check("period2", 8'(nfr), 8'd2);
        apples(10);
        check("lvl_sat", 8'(bus.level), 8'd7);

        // Pause mid-period
        frame();
        step(EV_PK, RIGHT);
        idle(1);
        check("paused", 8'(bus.state), 8'(ST_PAUSED));
        t0 = tick_seen;
        repeat (20) frame();
        check("pause_no_ticks", 8'(tick_seen - t0), 8'd0);
        step(EV_PK, RIGHT);
        idle(1);
        check("resumed", 8'(bus.state), 8'(ST_PLAYING));
        run_to_tick(20, nfr);
        check("resume_frozen_cnt", 8'(nfr), 8'd1);

        // Reset on the frame that would produce a tick
        frame();
        t0 = tick_seen;
        step(EV_FS | EV_RST, RIGHT);
        idle(3);
        check("mrst_no_tick", 8'(tick_seen - t0), 8'd0);
        check("mrst_state", 8'(bus.state), 8'(ST_IDLE));
        check("mrst_rg", 8'(bus.reset_game), 8'd1);
        check("mrst_level", 8'(bus.level), 8'd0);
        check("mrst_dir", 8'(bus.direction), 8'(RIGHT));

        // Randomized play against the model
        step(EV_SK, RIGHT);
        for (int i = 0; i < 4000; i++) begin
            ev = 8'h00;
            if ($urandom_range(0, 3) == 0)    ev = ev | EV_FS;
            if ($urandom_range(0, 99) == 0)   ev = ev | EV_SK;
            if ($urandom_range(0, 149) == 0)  ev = ev | EV_PK;
            if ($urandom_range(0, 5) == 0)    ev = ev | EV_DV;
            if ($urandom_range(0, 39) == 0)   ev = ev | EV_AP;
            if ($urandom_range(0, 399) == 0)  ev = ev | EV_GO;
            if ($urandom_range(0, 999) == 0)  ev = ev | EV_RST;
            step(ev, dir_t'(2'($urandom_range(0, 3))));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
